// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, descriptor/state types and the shared encoder.
// Shared by the encoder RTL and by benches that need reference encodings.
package rv_isa_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_L = 7'b0000011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [6:0] OPC_U = 7'b0110111;
    localparam logic [6:0] OPC_J = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_L   = 3'd2,
        CLS_S   = 3'd3,
        CLS_B   = 3'd4,
        CLS_U   = 3'd5,
        CLS_J   = 3'd6,
        CLS_RSV = 3'd7
    } op_class_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        op_class_e       cls;
        logic [2:0]      func3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
    } op_desc_t;

    // Assemble one instruction word; the reserved class yields a NOP.
    function automatic logic [XLEN-1:0] encode(input op_desc_t d);
        logic [6:0]      f7;
        logic [XLEN-1:0] w;
        f7 = d.alt ? F7_ALT : F7_BASE;
        w  = NOP;
        case (d.cls)
            CLS_R: w = {f7, d.rs2, d.rs1, d.func3, d.rd, OPC_R};
            CLS_I: begin
                // Shift-immediates carry func7 in the upper immediate bits.
                if (d.func3 == F3_SLL || d.func3 == F3_SR)
                    w = {f7, d.imm[4:0], d.rs1, d.func3, d.rd, OPC_I};
                else
                    w = {d.imm[11:0], d.rs1, d.func3, d.rd, OPC_I};
            end
            CLS_L: w = {d.imm[11:0], d.rs1, d.func3, d.rd, OPC_L};
            CLS_S: w = {d.imm[11:5], d.rs2, d.rs1, d.func3, d.imm[4:0], OPC_S};
            CLS_B: w = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, d.func3,
                        d.imm[4:1], d.imm[11], OPC_B};
            CLS_U: w = {d.imm[31:12], d.rd, OPC_U};
            CLS_J: w = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, OPC_J};
            default: w = NOP;
        endcase
        return w;
    endfunction

    // Flag descriptors that do not map onto a legal RV32I instruction.
    function automatic logic is_illegal(input op_desc_t d);
        logic ill;
        ill = 1'b0;
        case (d.cls)
            CLS_R:   ill = d.alt && !(d.func3 == F3_ADD || d.func3 == F3_SR);
            CLS_I:   ill = d.alt && (d.func3 != F3_SR);
            CLS_L:   ill = (d.func3 == 3'd3) || (d.func3 >= 3'd6);
            CLS_S:   ill = (d.func3 > 3'd2);
            CLS_B:   ill = (d.func3 == 3'd2) || (d.func3 == 3'd3);
            CLS_RSV: ill = 1'b1;
            default: ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Descriptor input and instruction-memory write channels of the encoder.
//  op_*  : descriptor valid/ready channel (master drives, encoder accepts)
//  iw_*  : imem write valid/ready channel (encoder drives, master accepts)
interface rv_instr_encoder_if;

    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_class;
    logic [2:0]  op_func3;
    logic        op_alt;
    logic [4:0]  op_rd;
    logic [4:0]  op_rs1;
    logic [4:0]  op_rs2;
    logic [31:0] op_imm;

    logic        iw_valid;
    logic        iw_ready;
    logic [31:0] iw_addr;
    logic [31:0] iw_data;

    modport master (
        output op_valid, op_class, op_func3, op_alt, op_rd, op_rs1, op_rs2, op_imm,
        input  op_ready,
        input  iw_valid, iw_addr, iw_data,
        output iw_ready
    );

    modport slave (
        input  op_valid, op_class, op_func3, op_alt, op_rd, op_rs1, op_rs2, op_imm,
        output op_ready,
        output iw_valid, iw_addr, iw_data,
        input  iw_ready
    );

endinterface

// File: rtl/rv_instr_fifo.sv
// Small instruction-word FIFO with registered full/empty flags.
//  clk, reset        : clock, async active-high reset
//  push, push_data   : write (ignored when full)
//  pop, pop_data     : read (ignored when empty); pop_data reads 0 while empty
//  full, empty       : occupancy flags
module rv_instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy next value; flags are registered from it.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + CNT_W'(1);
        else if (do_pop && !do_push)
            count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Masking keeps the output at zero after reset without clearing storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: turns op descriptors into words and writes
// them to imem at consecutive addresses from a loaded base PC.
// Optional build macro ENC_ILLEGAL_CHECK_EN drops illegal descriptors and
// adds the illegal pulse and err_count outputs.
//  clk, reset   : clock, async active-high reset
//  start        : load base address {start_addr[31:2],2'b00}, enter RUN
//  stop         : stop accepting, drain FIFO, return to IDLE
//  bus          : descriptor (op_*) and imem write (iw_*) channels
//  busy         : state != IDLE
//  emitted      : saturating count of words written, cleared on start
//  illegal      : (macro) one-cycle pulse per dropped descriptor
//  err_count    : (macro) saturating count of dropped descriptors
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic                stop,
    rv_instr_encoder_if.slave   bus,
    output logic                busy,
    output logic [CNT_W-1:0]    emitted
`ifdef ENC_ILLEGAL_CHECK_EN
    ,
    output logic                illegal,
    output logic [CNT_W-1:0]    err_count
`endif
);

    state_e          state;
    logic [31:0]     addr_q;
    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;
    logic            start_ok;
    op_desc_t        desc;
    logic [XLEN-1:0] word;

    assign desc = '{
        cls:   op_class_e'(bus.op_class),
        func3: bus.op_func3,
        alt:   bus.op_alt,
        rd:    bus.op_rd,
        rs1:   bus.op_rs1,
        rs2:   bus.op_rs2,
        imm:   bus.op_imm
    };
    assign word = encode(desc);

    assign bus.op_ready = (state == RUN) && !full;
    assign accept       = bus.op_valid && bus.op_ready;
    assign bus.iw_valid = !empty;
    assign pop          = bus.iw_valid && bus.iw_ready;
    assign bus.iw_addr  = addr_q;
    assign busy         = (state != IDLE);
    assign start_ok     = (state == IDLE) && start;

`ifdef ENC_ILLEGAL_CHECK_EN
    logic ill_c;
    assign ill_c = is_illegal(desc);
    assign push  = accept && !ill_c;

    // Dropped-descriptor pulse and saturating error count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal   <= 1'b0;
            err_count <= '0;
        end else begin
            illegal <= accept && ill_c;
            if (start_ok)
                err_count <= '0;
            else if (accept && ill_c && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
        end
    end
`else
    assign push = accept;
`endif

    rv_instr_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (bus.iw_data),
        .full      (full),
        .empty     (empty)
    );

    // Control FSM plus write address and emitted counter. A pop never
    // coincides with start because the FIFO is always empty in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            emitted <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        addr_q  <= {start_addr[31:2], 2'b00};
                        emitted <= '0;
                    end
                end
                RUN:     if (stop)  state <= DRAIN;
                DRAIN:   if (empty) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (pop) begin
                addr_q <= addr_q + 32'd4;
                if (emitted != '1) emitted <= emitted + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder with hand-computed instruction words.
module tb_rv_instr_encoder;
    import rv_isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_addr;
    logic        stop;
    logic        busy;
    logic [15:0] emitted;
`ifdef ENC_ILLEGAL_CHECK_EN
    logic        illegal;
    logic [15:0] err_count;
`endif

    int checks   = 0;
    int failures = 0;

    rv_instr_encoder_if bus ();

    rv_instr_encoder #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .bus        (bus),
        .busy       (busy),
        .emitted    (emitted)
`ifdef ENC_ILLEGAL_CHECK_EN
        ,
        .illegal    (illegal),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic with_stop);
        start      = 1'b1;
        start_addr = a;
        stop       = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        bus.op_class = cls;
        bus.op_func3 = f3;
        bus.op_alt   = alt;
        bus.op_rd    = rd;
        bus.op_rs1   = rs1;
        bus.op_rs2   = rs2;
        bus.op_imm   = imm;
    endtask

    task automatic send_op(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        int n = 0;
        set_op(cls, f3, alt, rd, rs1, rs2, imm);
        bus.op_valid = 1'b1;
        while (!bus.op_ready && n < 20) begin
            tick();
            n++;
        end
        check("op_ready_wait", 32'(bus.op_ready), 32'd1);
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!bus.iw_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.iw_valid), 32'd1);
        check({tag, "_addr"}, bus.iw_addr, a);
        check({tag, "_data"}, bus.iw_data, d);
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] addi_tab [6];
        int acc;
        addi_tab[0] = 32'h0010_0093;
        addi_tab[1] = 32'h0020_0093;
        addi_tab[2] = 32'h0030_0093;
        addi_tab[3] = 32'h0040_0093;
        addi_tab[4] = 32'h0050_0093;
        addi_tab[5] = 32'h0060_0093;

        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        start_addr   = '0;
        bus.op_valid = 1'b0;
        bus.iw_ready = 1'b1;
        set_op(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check("rst_iw_valid", 32'(bus.iw_valid), 32'd0);
        check("rst_iw_addr", bus.iw_addr, 32'd0);
        check("rst_iw_data", bus.iw_data, 32'd0);
        check("rst_emitted", 32'(emitted), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // 1: unaligned base, addi x1,x2,-1
        do_start(32'h0000_0103, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_op_ready", 32'(bus.op_ready), 32'd1);
        check("t1_base", bus.iw_addr, 32'h0000_0100);
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        check("t1_latency", 32'(bus.iw_valid), 32'd1);
        expect_word("t1_addi", 32'h0000_0100, 32'hFFF1_0093);
        check("t1_emitted", 32'(emitted), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("t1_idle");

        // 2: sub and srai from a fresh base
        do_start(32'h0000_0100, 1'b0);
        check("t2_emitted_clr", 32'(emitted), 32'd0);
        send_op(3'(CLS_R), 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("t2_sub", 32'h0000_0100, 32'h4020_81B3);
        send_op(3'(CLS_I), 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3);
        expect_word("t2_srai", 32'h0000_0104, 32'h4033_5293);

        // 3: store, load, lui
        send_op(3'(CLS_S), 3'd2, 1'b0, 5'd0, 5'd2, 5'd7, 32'd8);
        expect_word("t3_sw", 32'h0000_0108, 32'h0071_2423);
        send_op(3'(CLS_L), 3'd2, 1'b0, 5'd4, 5'd1, 5'd0, 32'hFFFF_FFFC);
        expect_word("t3_lw", 32'h0000_010C, 32'hFFC0_A203);
        send_op(3'(CLS_U), 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'h1234_5000);
        expect_word("t3_lui", 32'h0000_0110, 32'h1234_54B7);

        // 4: branch and jump
        send_op(3'(CLS_B), 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16);
        expect_word("t4_beq", 32'h0000_0114, 32'h0020_8863);
        send_op(3'(CLS_J), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        expect_word("t4_jal", 32'h0000_0118, 32'h0010_00EF);
        check("t4_emitted", 32'(emitted), 32'd7);

        // 5: backpressure with a continuous op stream
        bus.iw_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            set_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(acc + 1));
            bus.op_valid = 1'b1;
            if (bus.iw_valid) begin
                check("t5_hold_data", bus.iw_data, addi_tab[0]);
                check("t5_hold_addr", bus.iw_addr, 32'h0000_011C);
            end
            if (bus.op_ready) acc++;
            tick();
        end
        bus.op_valid = 1'b0;
        check("t5_accepts", 32'(acc), 32'd4);
        check("t5_full_ready", 32'(bus.op_ready), 32'd0);
        bus.iw_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            expect_word("t5_word", 32'h0000_011C + 32'(4 * k), addi_tab[k]);
        check("t5_no_dup", 32'(bus.iw_valid), 32'd0);
        check("t5_emitted", 32'(emitted), 32'd11);

        // 6: stop with three queued words, then wrap at top of address space
        bus.iw_ready = 1'b0;
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd6);
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_drain_busy", 32'(busy), 32'd1);
        check("t6_drain_ready", 32'(bus.op_ready), 32'd0);
        bus.iw_ready = 1'b1;
        expect_word("t6_d0", 32'h0000_012C, 32'h0050_0093);
        expect_word("t6_d1", 32'h0000_0130, 32'h0060_0093);
        expect_word("t6_d2", 32'h0000_0134, 32'h0070_0093);
        wait_idle("t6_idle");
        check("t6_emitted", 32'(emitted), 32'd14);

        do_start(32'hFFFF_FFFC, 1'b1);
        check("t6_start_wins", 32'(busy), 32'd1);
        check("t6_ready", 32'(bus.op_ready), 32'd1);
        check("t6_emitted_clr", 32'(emitted), 32'd0);
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        expect_word("t6_top", 32'hFFFF_FFFC, 32'h0080_0093);
        do_start(32'h0000_0200, 1'b0);
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
        expect_word("t6_wrap", 32'h0000_0000, 32'h0090_0093);
        check("t6_emitted2", 32'(emitted), 32'd2);

        // Reserved class
        send_op(3'(CLS_RSV), 3'd0, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0);
`ifdef ENC_ILLEGAL_CHECK_EN
        check("rsv_illegal", 32'(illegal), 32'd1);
        check("rsv_dropped", 32'(bus.iw_valid), 32'd0);
        check("rsv_err_count", 32'(err_count), 32'd1);
`else
        expect_word("rsv_nop", 32'h0000_0004, 32'h0000_0013);
`endif

        // Reset mid-operation
        bus.iw_ready = 1'b0;
        send_op(3'(CLS_I), 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd10);
        check("mid_queued", 32'(bus.iw_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_iw_valid", 32'(bus.iw_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_op_ready", 32'(bus.op_ready), 32'd0);
        check("mid_iw_addr", bus.iw_addr, 32'd0);
        check("mid_iw_data", bus.iw_data, 32'd0);
        check("mid_emitted", 32'(emitted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
